// File: rtl/sumador_pkg.sv
// Shared types and default sizing for the sequential adder/subtractor.
package sumador_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/sumador_bloque.sv
// Combinational CHUNK-bit ripple slice; c_msb is the carry into the slice MSB.
module sumador_bloque #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
    // Carry into the top bit recovered from the top-bit sum, valid for CHUNK=1 too.
    c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered
// carry between slices and valid/ready handshakes on both sides.
module sumador_secuencial
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("sumador_secuencial: WIDTH must be a multiple of CHUNK");
  end

  estado_t          state, state_nx;
  logic [KW-1:0]    k, k_nx;
  logic [WIDTH-1:0] a_r, a_nx, b_r, b_nx, acc, acc_nx, sum_nx;
  logic             carry, carry_nx, cout_nx, ovf_nx;
  logic [31:0]      off;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl, c_msb_sl;

  // Slice k of the latched operands feeds the single shared ripple slice.
  assign off  = 32'(k) * CHUNK;
  assign a_sl = CHUNK'(a_r >> off);
  assign b_sl = CHUNK'(b_r >> off);

  sumador_bloque #(.CHUNK(CHUNK)) u_bloque (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry),
    .s     (s_sl),
    .cout  (c_sl),
    .c_msb (c_msb_sl)
  );

  always_comb begin
    state_nx = state;
    k_nx     = k;
    a_nx     = a_r;
    b_nx     = b_r;
    carry_nx = carry;
    acc_nx   = acc;
    sum_nx   = sum;
    cout_nx  = cout;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nx     = a;
          b_nx     = sub ? ~b : b;
          carry_nx = sub ? ~cin : cin;
          k_nx     = '0;
          state_nx = CALC;
        end
      end
      CALC: begin
        acc_nx   = (acc & ~(SLICE_MASK << off)) | (WIDTH'(s_sl) << off);
        carry_nx = c_sl;
        k_nx     = k + KW'(1);
        if (k == KW'(N - 1)) begin
          sum_nx   = acc_nx;
          cout_nx  = c_sl;
          ovf_nx   = c_msb_sl ^ c_sl;
          k_nx     = '0;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      acc       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      a_r       <= a_nx;
      b_r       <= b_nx;
      carry     <= carry_nx;
      acc       <= acc_nx;
      sum       <= sum_nx;
      cout      <= cout_nx;
      ovf       <= ovf_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_sumador_secuencial.sv
// Self-checking bench: three sizings (CHUNK 8, 64, 1) against an arithmetic reference.
module tb_sumador_secuencial;

  localparam int W  = 64;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin, sub, out_ready;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         cout      [NI];
  logic         ovf       [NI];
  logic [W-1:0] sum       [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sumador_secuencial #(.WIDTH(64), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

  sumador_secuencial #(.WIDTH(64), .CHUNK(64)) u_c64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

  sumador_secuencial #(.WIDTH(64), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
    .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  vec_t vt [6];

  function automatic int lat_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 1 : 64);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, unsigned for carry/borrow, signed range for overflow.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sb, output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0]          u;
    logic signed [W+1:0] sx, sy, sc, r, maxv, minv;
    sx   = {{2{x[W-1]}}, x};
    sy   = {{2{y[W-1]}}, y};
    sc   = (W+2)'(ci);
    maxv = {3'b000, {(W-1){1'b1}}};
    minv = {3'b111, {(W-1){1'b0}}};
    if (!sb) begin
      u  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      s  = u[W-1:0];
      co = u[W];
      r  = sx + sy + sc;
    end else begin
      s  = x - y - W'(ci);
      co = ({1'b0, x} >= ({1'b0, y} + (W+1)'(ci)));
      r  = sx - sy - sc;
    end
    ov = (r > maxv) || (r < minv);
  endtask

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Issue one operation on instance d, check latency and result; optionally complete handshake.
  task automatic do_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb, input logic [W-1:0] es,
                       input logic ec, input logic eo, input string nm, input bit hs);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready"}, W'(in_ready[d]), W'(1));
    if (!in_ready[d]) return;
    a = x; b = y; cin = ci; sub = sb; in_valid[d] = 1'b1;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid[d] && lat < 200);
    chk({nm, " latency"}, W'(lat), W'(lat_of(d)));
    chk({nm, " sum"}, sum[d], es);
    chk({nm, " cout"}, W'(cout[d]), W'(ec));
    chk({nm, " ovf"}, W'(ovf[d]), W'(eo));
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] x, y, es;
    logic         ci, sb, ec, eo;

    rst_n = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    chk("reset in_ready", W'(in_ready[0]), W'(1));
    chk("reset out_valid", W'(out_valid[0]), W'(0));
    chk("reset sum", sum[0], '0);
    chk("reset cout_ovf", W'({cout[0], ovf[0]}), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[2] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[4] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vt[5] = '{64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    for (int d = 0; d < NI; d++)
      for (int i = 0; i < 6; i++)
        do_op(d, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].s, vt[i].co, vt[i].ov,
              $sformatf("vec%0d/inst%0d", i, d), 1'b1);

    // Backpressure: result held, new operands ignored while out_ready is low.
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = rnd64(); b = rnd64(); cin = 1'b1; in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp out_valid", W'(out_valid[0]), W'(1));
      chk("bp in_ready", W'(in_ready[0]), W'(0));
      chk("bp sum", sum[0], 64'h8000_0000_0000_0000);
      chk("bp cout_ovf", W'({cout[0], ovf[0]}), W'(2'b01));
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp release in_ready", W'(in_ready[0]), W'(1));
    chk("bp release out_valid", W'(out_valid[0]), W'(0));
    chk("bp hold sum", sum[0], 64'h8000_0000_0000_0000);
    do_op(0, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, "bp next", 1'b1);

    // Reset during the third CALC cycle discards the operation.
    do_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "pre rst", 1'b1);
    @(negedge clk);
    a = 64'h1234; b = 64'h1111; cin = 1'b1; sub = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst out_valid", W'(out_valid[0]), W'(0));
    chk("rst sum", sum[0], '0);
    chk("rst cout_ovf", W'({cout[0], ovf[0]}), W'(0));
    chk("rst in_ready", W'(in_ready[0]), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rst no partial", W'(out_valid[0]), W'(0));
    do_op(0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, "post rst", 1'b1);

    // Random operations on the single-cycle and bit-serial sizings.
    for (int i = 0; i < 1000; i++) begin
      x = rnd64(); y = rnd64(); ci = 1'($urandom()); sb = 1'($urandom());
      model(x, y, ci, sb, es, ec, eo);
      do_op(1, x, y, ci, sb, es, ec, eo, $sformatf("rnd64 #%0d", i), 1'b1);
    end
    for (int i = 0; i < 400; i++) begin
      x = rnd64(); y = rnd64(); ci = 1'($urandom()); sb = 1'($urandom());
      model(x, y, ci, sb, es, ec, eo);
      do_op(2, x, y, ci, sb, es, ec, eo, $sformatf("rnd1 #%0d", i), 1'b1);
    end
    for (int i = 0; i < 100; i++) begin
      x = rnd64(); y = rnd64(); ci = 1'($urandom()); sb = 1'($urandom());
      model(x, y, ci, sb, es, ec, eo);
      do_op(0, x, y, ci, sb, es, ec, eo, $sformatf("rnd8 #%0d", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
